// File: rtl/spi_reg_pkg.sv
// Shared constants and state encoding for the SPI register responder.
// Optional feature macro: SPI_SOFT_RESET_EN (soft reset via bit 5 of address 0x00).
package spi_reg_pkg;

    localparam int ADDR_W        = 5;
    localparam int DATA_W        = 8;
    localparam int NUM_REGS      = 32;
    localparam int NUM_RW_REGS   = 31;
    localparam logic [ADDR_W-1:0] ID_ADDR = 5'h1F;
    localparam int SOFT_RST_BIT  = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INSTR = 2'd1,
        ST_DATA  = 2'd2,
        ST_DONE  = 2'd3
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall detection
// on the synchronized level. Flops reset to the line's idle level so that the
// reset release does not look like an edge.
module spi_sync_edge
    import spi_reg_pkg::*;
#(
    parameter int   STAGES     = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // Shift the raw input through the synchronizer chain and remember the last synchronized level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{IDLE_LEVEL}};
            prev  <= IDLE_LEVEL;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = chain[STAGES-1] & ~prev;
    assign fall  = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 target exposing a 32 x 8 register file. Instruction byte is
// {R/W, N[1:0], A[4:0]} followed by N+1 data bytes at descending addresses.
// Address 0x1F is a read-only chip ID.
// Optional feature macro: SPI_SOFT_RESET_EN -- writing 1 to bit 5 of address
// 0x00 clears registers 0x00..0x1E one cycle after the write strobe.
module spi_reg_responder
    import spi_reg_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CHIP_ID     = 8'h0A
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         spi_scs_in,
    input  logic         spi_sck_in,
    input  logic         spi_sdi_in,
    output logic         spi_sdo_out,
    output logic         spi_sdo_oe_out,
    output logic         wr_stb_out,
    output logic [4:0]   wr_addr_out,
    output logic [7:0]   wr_data_out,
    output logic [255:0] regs_out
);

    logic scs_sync, sck_sync_unused, sdi_sync;
    logic sck_rise, sck_fall;
    logic scs_rise_unused, scs_fall_unused, sdi_rise_unused, sdi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_scs (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .din   (spi_scs_in),
        .level (scs_sync),
        .rise  (scs_rise_unused),
        .fall  (scs_fall_unused)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_sck (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .din   (spi_sck_in),
        .level (sck_sync_unused),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_sdi (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .din   (spi_sdi_in),
        .level (sdi_sync),
        .rise  (sdi_rise_unused),
        .fall  (sdi_fall_unused)
    );

    spi_state_t                       state;
    logic [2:0]                       bit_cnt;
    logic [1:0]                       byte_cnt;
    logic [ADDR_W-1:0]                addr;
    logic                             is_read;
    logic [DATA_W-2:0]                rx_shift;
    logic [DATA_W-2:0]                tx_shift;
    logic [NUM_RW_REGS*DATA_W-1:0]    reg_file;
    logic [DATA_W-1:0]                rx_byte;
    logic [DATA_W-1:0]                rd_byte;
`ifdef SPI_SOFT_RESET_EN
    logic                             soft_clr;
`endif

    assign regs_out = {CHIP_ID, reg_file};
    assign rx_byte  = {rx_shift, sdi_sync};
    assign rd_byte  = regs_out[{addr, 3'b000} +: DATA_W];

    // Protocol engine: shifts instruction and data bits, commits writes, and drives read data.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= ST_IDLE;
            bit_cnt        <= '0;
            byte_cnt       <= '0;
            addr           <= '0;
            is_read        <= 1'b0;
            rx_shift       <= '0;
            tx_shift       <= '0;
            reg_file       <= '0;
            spi_sdo_out    <= 1'b0;
            spi_sdo_oe_out <= 1'b0;
            wr_stb_out     <= 1'b0;
            wr_addr_out    <= '0;
            wr_data_out    <= '0;
`ifdef SPI_SOFT_RESET_EN
            soft_clr       <= 1'b0;
`endif
        end else begin
            wr_stb_out <= 1'b0;
`ifdef SPI_SOFT_RESET_EN
            soft_clr <= 1'b0;
            if (soft_clr) begin
                reg_file <= '0;
            end
`endif
            if (scs_sync) begin
                state          <= ST_IDLE;
                bit_cnt        <= '0;
                spi_sdo_out    <= 1'b0;
                spi_sdo_oe_out <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state   <= ST_INSTR;
                        bit_cnt <= '0;
                    end
                    ST_INSTR: begin
                        if (sck_rise) begin
                            rx_shift <= rx_byte[DATA_W-2:0];
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                is_read        <= rx_shift[6];
                                byte_cnt       <= rx_shift[5:4];
                                addr           <= {rx_shift[3:0], sdi_sync};
                                spi_sdo_oe_out <= rx_shift[6];
                                state          <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sck_rise) begin
                            rx_shift <= rx_byte[DATA_W-2:0];
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (!is_read && addr != ID_ADDR) begin
                                    for (int i = 0; i < NUM_RW_REGS; i++) begin
                                        if (addr == ADDR_W'(i)) begin
                                            reg_file[8*i +: 8] <= rx_byte;
                                        end
                                    end
                                    wr_stb_out  <= 1'b1;
                                    wr_addr_out <= addr;
                                    wr_data_out <= rx_byte;
`ifdef SPI_SOFT_RESET_EN
                                    if (addr == '0 && rx_byte[SOFT_RST_BIT]) begin
                                        soft_clr <= 1'b1;
                                    end
`endif
                                end
                                addr <= addr - 5'd1;
                                if (byte_cnt == 2'd0) begin
                                    state          <= ST_DONE;
                                    spi_sdo_oe_out <= 1'b0;
                                    spi_sdo_out    <= 1'b0;
                                end else begin
                                    byte_cnt <= byte_cnt - 2'd1;
                                end
                            end
                        end else if (sck_fall && is_read) begin
                            if (bit_cnt == 3'd0) begin
                                spi_sdo_out <= rd_byte[7];
                                tx_shift    <= rd_byte[6:0];
                            end else begin
                                spi_sdo_out <= tx_shift[6];
                                tx_shift    <= {tx_shift[5:0], 1'b0};
                            end
                        end
                    end
                    default: begin
                        state <= ST_DONE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed self-checking bench for spi_reg_responder.
// Covers reset state, single and burst writes, ID/normal/burst reads, partial
// byte abort, DONE-state ignore, the SPI_SOFT_RESET_EN option and async reset.
module tb_spi_reg_responder;

    localparam int HALF = 8;

    logic         clk_in     = 1'b0;
    logic         rst_n_in   = 1'b0;
    logic         spi_scs_in = 1'b1;
    logic         spi_sck_in = 1'b0;
    logic         spi_sdi_in = 1'b0;
    logic         spi_sdo_out;
    logic         spi_sdo_oe_out;
    logic         wr_stb_out;
    logic [4:0]   wr_addr_out;
    logic [7:0]   wr_data_out;
    logic [255:0] regs_out;

    int checks = 0;
    int errors = 0;
    int oe_cycles = 0;
    logic [4:0] stb_addr [$];
    logic [7:0] stb_data [$];
    logic [7:0] model [0:31];
    logic [7:0] r0, r1;

    spi_reg_responder #(.SYNC_STAGES(2), .CHIP_ID(8'h0A)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .spi_scs_in     (spi_scs_in),
        .spi_sck_in     (spi_sck_in),
        .spi_sdi_in     (spi_sdi_in),
        .spi_sdo_out    (spi_sdo_out),
        .spi_sdo_oe_out (spi_sdo_oe_out),
        .wr_stb_out     (wr_stb_out),
        .wr_addr_out    (wr_addr_out),
        .wr_data_out    (wr_data_out),
        .regs_out       (regs_out)
    );

    // Free-running system clock, 10 ns period.
    always #5 clk_in = ~clk_in;

    // Record every write strobe and count cycles with the SDO driver enabled.
    always @(negedge clk_in) begin
        if (wr_stb_out) begin
            stb_addr.push_back(wr_addr_out);
            stb_data.push_back(wr_data_out);
        end
        if (spi_sdo_oe_out) begin
            oe_cycles++;
        end
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [255:0] modelFlat();
        logic [255:0] r;
        for (int i = 0; i < 32; i++) begin
            r[8*i +: 8] = model[i];
        end
        return r;
    endfunction

    task automatic resetModel();
        for (int i = 0; i < 31; i++) begin
            model[i] = 8'h00;
        end
        model[31] = 8'h0A;
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic clearMonitors();
        stb_addr.delete();
        stb_data.delete();
        oe_cycles = 0;
    endtask

    // Shift nbits of tx MSB first; rx collects sdo just before each rising sck.
    task automatic applyStimulus(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 7; b >= 8 - nbits; b--) begin
            spi_sdi_in = tx[b];
            waitClk(HALF);
            rx[b] = spi_sdo_out;
            spi_sck_in = 1'b1;
            waitClk(HALF);
            spi_sck_in = 1'b0;
        end
    endtask

    task automatic beginTxn();
        clearMonitors();
        spi_scs_in = 1'b0;
        waitClk(HALF);
    endtask

    task automatic endTxn();
        waitClk(HALF);
        spi_scs_in = 1'b1;
        spi_sdi_in = 1'b0;
        waitClk(2 * HALF);
    endtask

    task automatic spiWrite(input logic [4:0] a, input logic [1:0] n,
                            input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        logic [7:0] dummy;
        beginTxn();
        applyStimulus({1'b0, n, a}, 8, dummy);
        applyStimulus(d0, 8, dummy);
        if (n >= 2'd1) applyStimulus(d1, 8, dummy);
        if (n >= 2'd2) applyStimulus(d2, 8, dummy);
        endTxn();
    endtask

    task automatic spiRead(input logic [4:0] a, input logic [1:0] n,
                           output logic [7:0] q0, output logic [7:0] q1);
        logic [7:0] dummy;
        q1 = 8'h00;
        beginTxn();
        applyStimulus({1'b1, n, a}, 8, dummy);
        applyStimulus(8'h00, 8, q0);
        if (n >= 2'd1) applyStimulus(8'h00, 8, q1);
        endTxn();
    endtask

    // Main directed sequence.
    initial begin
        logic [7:0] dummy;
        resetModel();

        waitClk(4);
        checkOutput("reset_regs",    regs_out,       modelFlat());
        checkOutput("reset_sdo",     spi_sdo_out,    1'b0);
        checkOutput("reset_oe",      spi_sdo_oe_out, 1'b0);
        checkOutput("reset_stb",     wr_stb_out,     1'b0);
        checkOutput("reset_wr_addr", wr_addr_out,    5'd0);
        checkOutput("reset_wr_data", wr_data_out,    8'd0);
        rst_n_in = 1'b1;
        waitClk(4);

        spiWrite(5'h05, 2'd0, 8'hA5, 8'h00, 8'h00);
        model[5] = 8'hA5;
        checkOutput("wr5_stb_count", stb_addr.size(), 1);
        if (stb_addr.size() == 1) begin
            checkOutput("wr5_stb_addr", stb_addr[0], 5'h05);
            checkOutput("wr5_stb_data", stb_data[0], 8'hA5);
        end
        checkOutput("wr5_reg", regs_out[47:40], 8'hA5);
        checkOutput("wr5_oe_low", oe_cycles, 0);

        spiRead(5'h1F, 2'd0, r0, r1);
        checkOutput("rd_id_data", r0, 8'h0A);
        checkOutput("rd_id_oe_cycles", oe_cycles, 8 * 2 * HALF);
        checkOutput("rd_id_no_stb", stb_addr.size(), 0);

        spiRead(5'h05, 2'd0, r0, r1);
        checkOutput("rd5_data", r0, 8'hA5);

        spiWrite(5'h01, 2'd2, 8'h11, 8'h22, 8'h33);
        model[1] = 8'h11;
        model[0] = 8'h22;
        checkOutput("burst_stb_count", stb_addr.size(), 2);
        if (stb_addr.size() == 2) begin
            checkOutput("burst_stb0", {stb_addr[0], stb_data[0]}, {5'h01, 8'h11});
            checkOutput("burst_stb1", {stb_addr[1], stb_data[1]}, {5'h00, 8'h22});
        end
        checkOutput("burst_regs", regs_out, modelFlat());

        spiRead(5'h01, 2'd1, r0, r1);
        checkOutput("rd_burst_b0", r0, 8'h11);
        checkOutput("rd_burst_b1", r1, 8'h22);
        checkOutput("rd_burst_oe_cycles", oe_cycles, 16 * 2 * HALF);

        beginTxn();
        applyStimulus(8'h03, 8, dummy);
        applyStimulus(8'hF0, 4, dummy);
        endTxn();
        checkOutput("partial_no_stb", stb_addr.size(), 0);
        checkOutput("partial_regs", regs_out, modelFlat());

        spiWrite(5'h03, 2'd0, 8'h3C, 8'h00, 8'h00);
        model[3] = 8'h3C;
        checkOutput("after_partial_stb", stb_addr.size(), 1);
        checkOutput("after_partial_regs", regs_out, modelFlat());

        beginTxn();
        applyStimulus(8'h04, 8, dummy);
        applyStimulus(8'h44, 8, dummy);
        applyStimulus(8'h55, 8, dummy);
        endTxn();
        model[4] = 8'h44;
        checkOutput("done_ignore_stb", stb_addr.size(), 1);
        checkOutput("done_ignore_regs", regs_out, modelFlat());

        spiWrite(5'h02, 2'd0, 8'h07, 8'h00, 8'h00);
        model[2] = 8'h07;
        checkOutput("wr2_reg", regs_out[23:16], 8'h07);
        spiWrite(5'h00, 2'd0, 8'h20, 8'h00, 8'h00);
        checkOutput("wr0_stb_count", stb_addr.size(), 1);
        if (stb_data.size() == 1) begin
            checkOutput("wr0_stb_data", stb_data[0], 8'h20);
        end
`ifdef SPI_SOFT_RESET_EN
        resetModel();
`else
        model[0] = 8'h20;
`endif
        checkOutput("soft_rst_regs", regs_out, modelFlat());
        spiRead(5'h00, 2'd0, r0, r1);
        checkOutput("soft_rst_rd0", r0, model[0]);
        spiRead(5'h1F, 2'd0, r0, r1);
        checkOutput("soft_rst_rd_id", r0, 8'h0A);

        beginTxn();
        applyStimulus(8'h85, 8, dummy);
        applyStimulus(8'h00, 3, dummy);
        checkOutput("midread_oe_high", spi_sdo_oe_out, 1'b1);
        waitClk(2);
        #2 rst_n_in = 1'b0;
        #1;
        checkOutput("async_rst_oe", spi_sdo_oe_out, 1'b0);
        checkOutput("async_rst_sdo", spi_sdo_out, 1'b0);
        spi_scs_in = 1'b1;
        waitClk(4);
        rst_n_in = 1'b1;
        waitClk(4);
        resetModel();
        checkOutput("post_rst_regs", regs_out, modelFlat());
        spiRead(5'h05, 2'd0, r0, r1);
        checkOutput("post_rst_rd5", r0, 8'h00);
        spiRead(5'h1F, 2'd0, r0, r1);
        checkOutput("post_rst_rd_id", r0, 8'h0A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
